// File: rtl/qsim_pkg.sv
// qsim shared definitions: accumulator FSM states, default widths,
// and signed saturation limits.
package qsim_pkg;

   typedef enum logic [1:0] {
      QACC_IDLE  = 2'd0,
      QACC_ACCUM = 2'd1,
      QACC_DONE  = 2'd2
   } qacc_state_e;

   localparam int QSIM_DWIDTH = 8;
   localparam int QSIM_AWIDTH = 24;
   localparam int QSIM_LWIDTH = 9;

   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/qsat_add.sv
// Combinational signed saturating adder: AWIDTH accumulator plus a
// narrower signed operand, clamped to the AWIDTH signed range.
module qsat_add
   import qsim_pkg::*;
#(
   parameter int AWIDTH = QSIM_AWIDTH,
   parameter int BWIDTH = 2 * QSIM_DWIDTH
) (
   input  logic [AWIDTH-1:0] i_acc,
   input  logic [BWIDTH-1:0] i_op,
   output logic [AWIDTH-1:0] o_sum,
   output logic              o_sat
);

   localparam logic [63:0]     MAX64 = sat_max(AWIDTH);
   localparam logic [63:0]     MIN64 = sat_min(AWIDTH);
   localparam logic [AWIDTH:0] MAXW  = MAX64[AWIDTH:0];
   localparam logic [AWIDTH:0] MINW  = MIN64[AWIDTH:0];

   // One guard bit suffices: acc is in range and BWIDTH < AWIDTH.
   logic [AWIDTH:0] w_acc_x;
   logic [AWIDTH:0] w_op_x;
   logic [AWIDTH:0] w_sum;

   assign w_acc_x = {i_acc[AWIDTH-1], i_acc};
   assign w_op_x  = {{(AWIDTH + 1 - BWIDTH){i_op[BWIDTH-1]}}, i_op};
   assign w_sum   = w_acc_x + w_op_x;

   always_comb begin
      o_sum = w_sum[AWIDTH-1:0];
      o_sat = 1'b0;
      if ($signed(w_sum) > $signed(MAXW)) begin
         o_sum = MAXW[AWIDTH-1:0];
         o_sat = 1'b1;
      end else if ($signed(w_sum) < $signed(MINW)) begin
         o_sum = MINW[AWIDTH-1:0];
         o_sat = 1'b1;
      end
   end

endmodule

// File: rtl/qacc.sv
// Signed saturating dot-product accumulator behind qmult: takes a job
// of i_len products over valid/ready and returns the clamped sum.
module qacc
   import qsim_pkg::*;
#(
   parameter int DWIDTH = QSIM_DWIDTH,
   parameter int AWIDTH = QSIM_AWIDTH,
   parameter int LWIDTH = QSIM_LWIDTH
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [LWIDTH-1:0]   i_len,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [2*DWIDTH-1:0] i_product,
   output logic                o_valid,
   input  logic                i_ready,
   output logic [AWIDTH-1:0]   o_result,
   output logic                o_overflow,
   output logic                o_busy
);

   qacc_state_e       r_state;
   qacc_state_e       w_state_nxt;
   logic [LWIDTH-1:0] r_cnt;
   logic [AWIDTH-1:0] r_acc;
   logic              r_ovf;
   logic              r_ready;
   logic              r_valid;
   logic              r_busy;

   logic              w_beat;
   logic              w_load;
   logic              w_last;
   logic [AWIDTH-1:0] w_sum;
   logic              w_sat;

   assign w_beat = r_ready & i_valid;
   assign w_load = (r_state == QACC_IDLE) & i_start;
   assign w_last = (r_cnt == LWIDTH'(1));

   qsat_add #(
      .AWIDTH (AWIDTH),
      .BWIDTH (2 * DWIDTH)
   ) u_add (
      .i_acc (r_acc),
      .i_op  (i_product),
      .o_sum (w_sum),
      .o_sat (w_sat)
   );

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         QACC_IDLE: begin
            if (i_start) begin
               w_state_nxt = (i_len == '0) ? QACC_DONE : QACC_ACCUM;
            end
         end
         QACC_ACCUM: begin
            if (w_beat && w_last) begin
               w_state_nxt = QACC_DONE;
            end
         end
         QACC_DONE: begin
            if (i_ready) begin
               w_state_nxt = QACC_IDLE;
            end
         end
         default: w_state_nxt = QACC_IDLE;
      endcase
   end

   // Handshake/busy flags are registered off the next state so every
   // output comes straight from a flop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= QACC_IDLE;
         r_ready <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == QACC_ACCUM);
         r_valid <= (w_state_nxt == QACC_DONE);
         r_busy  <= (w_state_nxt != QACC_IDLE);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_cnt <= '0;
      end else if (w_load) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
         r_cnt <= i_len;
      end else if (w_beat) begin
         r_acc <= w_sum;
         r_ovf <= r_ovf | w_sat;
         r_cnt <= r_cnt - LWIDTH'(1);
      end
   end

   assign o_ready    = r_ready;
   assign o_valid    = r_valid;
   assign o_busy     = r_busy;
   assign o_result   = r_acc;
   assign o_overflow = r_ovf;

endmodule

// File: tb/tb_qacc.sv
// Scoreboard bench for qacc: a default 24-bit and a 17-bit instance
// share stimulus; a negedge monitor checks each result handshake.
module tb_qacc;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [8:0]  len;
   logic        valid;
   logic [15:0] product;
   logic        rdy;

   logic        rdy24, vld24, ovf24, busy24;
   logic [23:0] res24;
   logic        rdy17, vld17, ovf17, busy17;
   logic [16:0] res17;

   typedef struct {
      int r24;
      int r17;
      int v24;
      int v17;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   qacc u_dut24 (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_len      (len),
      .i_valid    (valid),
      .o_ready    (rdy24),
      .i_product  (product),
      .o_valid    (vld24),
      .i_ready    (rdy),
      .o_result   (res24),
      .o_overflow (ovf24),
      .o_busy     (busy24)
   );

   qacc #(.AWIDTH(17)) u_dut17 (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_len      (len),
      .i_valid    (valid),
      .o_ready    (rdy17),
      .i_product  (product),
      .o_valid    (vld17),
      .i_ready    (rdy),
      .o_result   (res17),
      .o_overflow (ovf17),
      .o_busy     (busy17)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int s24(input logic [23:0] v);
      return int'($signed(v));
   endfunction

   function automatic int s17(input logic [16:0] v);
      return int'($signed(v));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int r24, input int r17,
                       input int v24, input int v17);
      exp_t e;
      e.r24 = r24;
      e.r17 = r17;
      e.v24 = v24;
      e.v17 = v17;
      q.push_back(e);
   endtask

   task automatic start_job(input int n);
      start = 1'b1;
      len   = 9'(n);
      step();
      start = 1'b0;
   endtask

   task automatic beat(input int p);
      valid   = 1'b1;
      product = 16'(p);
      step();
      valid   = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, int'(rdy24), 0);
      chk({tag, "_valid"}, int'(vld24), 0);
      chk({tag, "_result"}, s24(res24), 0);
      chk({tag, "_ovf"}, int'(ovf24), 0);
      chk({tag, "_busy"}, int'(busy24), 0);
      chk({tag, "_res17"}, s17(res17), 0);
      chk({tag, "_ovf17"}, int'(ovf17), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && vld24 && rdy) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected actual=%0d required=none",
                     s24(res24));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_res24", s24(res24), e.r24);
            chk("sb_ovf24", int'(ovf24), e.v24);
            chk("sb_vld17", int'(vld17), 1);
            chk("sb_res17", s17(res17), e.r17);
            chk("sb_ovf17", int'(ovf17), e.v17);
         end
      end
   end

   initial begin
      clk     = 1'b0;
      rst_n   = 1'b0;
      start   = 1'b0;
      len     = '0;
      valid   = 1'b0;
      product = '0;
      rdy     = 1'b1;
      step();
      step();
      chk_zero("reset");
      rst_n = 1'b1;
      step();

      // basic dot product, back-to-back beats
      push(16006, 16006, 0, 0);
      start_job(4);
      chk("t1_start_ready", int'(rdy24), 1);
      chk("t1_busy", int'(busy24), 1);
      beat(6);
      beat(-128);
      beat(16129);
      chk("t1_not_early", int'(vld24), 0);
      beat(-1);
      chk("t1_latency", int'(vld24), 1);
      step();
      chk("t1_idle", int'(busy24), 0);

      // upstream gaps and a 5-cycle downstream stall
      rdy = 1'b0;
      push(16512, 16512, 0, 0);
      start_job(3);
      beat(16384);
      step();
      step();
      chk("t2_gap_ready", int'(rdy24), 1);
      beat(16384);
      step();
      step();
      beat(-16256);
      for (int k = 0; k < 5; k++) begin
         chk("t2_hold_valid", int'(vld24), 1);
         chk("t2_hold_res", s24(res24), 16512);
         step();
      end
      rdy = 1'b1;
      step();
      chk("t2_idle_valid", int'(vld24), 0);
      chk("t2_idle_busy", int'(busy24), 0);

      // positive saturation on the 17-bit instance
      push(81920, 65535, 0, 1);
      start_job(5);
      beat(16384);
      beat(16384);
      beat(16384);
      chk("t3_ovf_pre", int'(ovf17), 0);
      beat(16384);
      chk("t3_ovf_4th", int'(ovf17), 1);
      chk("t3_clamp_4th", s17(res17), 65535);
      beat(16384);
      step();

      // negative saturation
      push(-81920, -65536, 0, 1);
      start_job(5);
      for (int k = 0; k < 4; k++) beat(-16384);
      chk("t4_ovf_pre", int'(ovf17), 0);
      beat(-16384);
      chk("t4_ovf_5th", int'(ovf17), 1);
      step();

      // zero-length job
      push(0, 0, 0, 0);
      start_job(0);
      chk("t5_zero_valid", int'(vld24), 1);
      step();

      // start during ACCUM is ignored
      push(-200, -200, 0, 0);
      start_job(2);
      start = 1'b1;
      len   = 9'd7;
      beat(100);
      start = 1'b0;
      beat(-300);
      chk("t5_ign_valid", int'(vld24), 1);
      step();
      chk("t5_ign_idle", int'(busy24), 0);

      // asynchronous reset mid-job
      start_job(4);
      beat(1000);
      beat(2000);
      valid   = 1'b1;
      product = 16'd3000;
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("t6_rst");
      valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      push(-1, -1, 0, 0);
      start_job(1);
      beat(-1);
      chk("t6_valid", int'(vld24), 1);
      step();
      step();

      chk("sb_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/qacc.md
# qacc

Signed accumulator stage directly downstream of the `qmult` 8×8 multiplier in the qsim datapath. It accepts a job of `i_len` signed 16-bit products over a valid/ready stream and sums them into a saturating AWIDTH-bit accumulator. It then presents the dot-product result on a valid/ready output. One job runs at a time, at a throughput of one product per cycle.

## Interface
- `DWIDTH`, 8: operand width of the upstream multiplier; products are 2*DWIDTH bits.
- `AWIDTH`, 24: accumulator and result width; must be ≥ 2*DWIDTH+1.
- `LWIDTH`, 9: width of the job-length field; max job length is 2^LWIDTH−1.
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst_n` in 1: **asynchronous, active-low reset**.
- `i_start` in 1: job start pulse; sampled only in IDLE.
- `i_len` in LWIDTH: unsigned product count for the job; sampled with `i_start`.
- `i_valid` in 1: upstream product valid.
- `o_ready` out 1: stage accepts a product this cycle.
- `i_product` in 2*DWIDTH: signed product, i.e. `qmult` `o_result`.
- `o_valid` out 1: result valid.
- `i_ready` in 1: downstream accepts the result.
- `o_result` out AWIDTH: signed accumulated sum.
- `o_overflow` out 1: sticky flag; set if any add in the current job saturated.
- `o_busy` out 1: high in ACCUM or DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE:**
  - `o_ready`=0 and `o_valid`=0.
  - On `i_start` with `i_len`≠0: clear acc to 0, clear `o_overflow`, load cnt=`i_len`, and go to ACCUM.
  - On `i_start` with `i_len`=0: clear acc and `o_overflow`, and go directly to DONE, so the result is 0.
- **ACCUM:**
  - `o_ready`=1.
  - Each beat with `i_valid`&&`o_ready` does the following:
    - sign-extends `i_product` to AWIDTH+1 bits;
    - adds it to acc;
    - saturates the sum to [−2^(AWIDTH−1), 2^(AWIDTH−1)−1];
    - sets `o_overflow` if it clamped;
    - decrements cnt.
  - When cnt==1 and a beat is accepted, go to DONE.
  - Cycles with `i_valid`=0 leave acc and cnt unchanged.
- **DONE:**
  - `o_valid`=1 and `o_result`=acc.
  - `o_result` and `o_overflow` stay stable while `i_ready`=0.
  - On `i_ready`, go to IDLE.
- `i_start` outside IDLE is ignored, with no effect on acc, cnt or flags.
- Once saturated, acc continues accumulating from the clamped value. Later beats may move it back in range, but `o_overflow` stays set until the next start.
- **Reset (any state, mid-job included):** state=IDLE; acc, cnt, `o_result`, `o_overflow`, `o_valid`, `o_ready` and `o_busy` are all 0. A partially accumulated job is discarded.

## Timing
- Start-to-ready: `o_ready` rises the cycle after `i_start` is sampled in IDLE.
- Throughput is 1 product per cycle in ACCUM, with no bubbles while `i_valid` is held high.
- Latency: `o_valid` rises the cycle after the last product handshake.
- Zero-length job: `o_valid` rises the cycle after `i_start`.
- Result handshake completes on the edge where `o_valid`&&`i_ready`. The next `i_start` is accepted at the earliest one cycle later (IDLE), giving a 1-cycle inter-job bubble.
- All outputs are registered. `o_ready` and `o_valid` depend only on state and never combinationally on `i_valid` or `i_ready`.

## Structure
- Shared package `qsim_pkg` holds:
  - the state enum (`QACC_IDLE`, `QACC_ACCUM`, `QACC_DONE`);
  - default width constants (DWIDTH, AWIDTH, LWIDTH);
  - saturation limit helpers for a given width.
- Sub-module `qsat_add`: combinational signed saturating adder (AWIDTH acc + 2*DWIDTH operand) with a `sat` flag output. It is reusable by later requantization stages.
- `qacc` contains the FSM, the length counter and the acc/flag registers.

## Test plan
- **Basic dot product:** start with len=4 and products 6, −128, 16129, −1 streamed back-to-back, `i_ready`=1.
  - `o_valid` rises 1 cycle after the 4th beat.
  - `o_result`=16006, `o_overflow`=0.
- **Upstream gaps and downstream stall:** len=3, products 16384, 16384, −16256, with `i_valid` low for 2 cycles between beats and `i_ready` low for 5 cycles.
  - Result is 16512, held stable for all 5 stall cycles.
  - Returns to IDLE on the `i_ready` edge.
- **Positive saturation:** AWIDTH=17, len=5, all products 16384.
  - `o_result`=65535.
  - `o_overflow`=1 from the 4th beat onward.
- **Negative saturation:** AWIDTH=17, len=5, all products −16384.
  - `o_result`=−65536.
  - `o_overflow`=1.
- **Zero length and ignored start:**
  - len=0 gives `o_valid` the next cycle with `o_result`=0.
  - A second `i_start` (len=7) asserted during ACCUM of a len=2 job is ignored; the result covers exactly 2 beats.
- **Reset mid-job:** pull `i_rst_n` low asynchronously after 2 of 4 beats.
  - All outputs are 0 immediately.
  - A new len=1 job with product −1 afterwards yields −1 with `o_overflow`=0.
